// File: rtl/ads5296_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : ads5296_pattern_checker
// Brief    : ADS5296 deserialized-sample test-pattern checker (fixed/ramp/toggle).
//            Optional per-channel counters: define ADS5296_CHK_PER_CHAN_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ads5296_pattern_checker #(
  parameter int G_NUM_UNITS   = 4,
  parameter int G_ARM_SAMPLES = 8
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic [40*G_NUM_UNITS-1:0] din,
  input  logic                      din_vld,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [9:0]                pattern,
  input  logic [31:0]               window_len,
  input  logic [7:0]                chan_sel,
  output logic                      busy,
  output logic                      done,
  output logic [4*G_NUM_UNITS-1:0]  err_mask,
  output logic [31:0]               total_err_cnt,
  output logic [31:0]               samples_checked,
  output logic [15:0]               chan_err_cnt
);

  localparam int         NCH           = 4*G_NUM_UNITS;
  localparam logic [1:0] C_MODE_RAMP   = 2'd1;
  localparam logic [1:0] C_MODE_TOGGLE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            start_acc, arm_last, run_vld, last_smp;
  logic [31:0]     arm_cnt_q;
  logic            fin_q;
  logic            seeded_q;
  logic [1:0]      mode_q;
  logic [9:0]      pattern_q;
  logic [31:0]     window_q;
  logic [9:0]      prev_q [NCH];
  logic [NCH-1:0]  mis_d, mis_q;
  logic [NCH-1:0]  err_mask_q;
  logic [31:0]     total_err_cnt_q;
  logic [31:0]     samples_q;
  logic [31:0]     pop;
  logic [32:0]     total_sum;

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d   = state_q;
    start_acc = start && !stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    arm_last  = (state_q == ST_ARM) && din_vld &&
                ((arm_cnt_q + 32'd1) >= 32'(G_ARM_SAMPLES));
    run_vld   = (state_q == ST_RUN) && din_vld && !fin_q && !stop;
    last_smp  = run_vld && (window_q != 32'd0) && (samples_q == (window_q - 32'd1));
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_ARM;
      ST_ARM: begin
        if (stop)          state_d = ST_IDLE;
        else if (arm_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        // fin_q delays DONE by one cycle so the counters settle first
        if (stop)       state_d = ST_IDLE;
        else if (fin_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------- compare
  always_comb begin
    mis_d = '0;
    for (int c = 0; c < NCH; c++) begin
      case (mode_q)
        C_MODE_RAMP:
          mis_d[c] = seeded_q && (din[10*c +: 10] != (prev_q[c] + 10'd1));
        C_MODE_TOGGLE:
          mis_d[c] = seeded_q ? (din[10*c +: 10] != ~prev_q[c])
                              : ((din[10*c +: 10] != pattern_q) &&
                                 (din[10*c +: 10] != ~pattern_q));
        default:
          mis_d[c] = (din[10*c +: 10] != pattern_q);
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++) pop = pop + 32'(mis_q[c]);
    total_sum = {1'b0, total_err_cnt_q} + {1'b0, pop};
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      arm_cnt_q       <= '0;
      fin_q           <= 1'b0;
      seeded_q        <= 1'b0;
      mode_q          <= '0;
      pattern_q       <= '0;
      window_q        <= '0;
      mis_q           <= '0;
      err_mask_q      <= '0;
      total_err_cnt_q <= '0;
      samples_q       <= '0;
      for (int c = 0; c < NCH; c++) prev_q[c] <= '0;
    end else if (start_acc) begin
      arm_cnt_q       <= '0;
      fin_q           <= 1'b0;
      seeded_q        <= 1'b0;
      mode_q          <= mode;
      pattern_q       <= pattern;
      window_q        <= window_len;
      mis_q           <= '0;
      err_mask_q      <= '0;
      total_err_cnt_q <= '0;
      samples_q       <= '0;
    end else begin
      fin_q           <= last_smp;
      mis_q           <= run_vld ? mis_d : '0;
      total_err_cnt_q <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
      if ((state_q == ST_ARM) && din_vld) arm_cnt_q <= arm_cnt_q + 32'd1;
      if (run_vld) begin
        err_mask_q <= err_mask_q | mis_d;
        seeded_q   <= 1'b1;
        if (samples_q != 32'hFFFF_FFFF) samples_q <= samples_q + 32'd1;
        // expected value always re-seeds from what was actually received
        for (int c = 0; c < NCH; c++) prev_q[c] <= din[10*c +: 10];
      end
    end
  end

`ifdef ADS5296_CHK_PER_CHAN_CNT_EN
  logic [15:0] cnt_q [NCH];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else if (start_acc) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (mis_q[c] && (cnt_q[c] != 16'hFFFF)) cnt_q[c] <= cnt_q[c] + 16'd1;
    end
  end

  always_comb begin
    chan_err_cnt = '0;
    for (int c = 0; c < NCH; c++)
      if (chan_sel == 8'(c)) chan_err_cnt = cnt_q[c];
  end
`else
  logic unused_chan_sel;
  assign unused_chan_sel = ^chan_sel;
  assign chan_err_cnt    = '0;
`endif

  assign busy            = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign err_mask        = err_mask_q;
  assign total_err_cnt   = total_err_cnt_q;
  assign samples_checked = samples_q;

endmodule
`default_nettype wire

// File: tb/tb_ads5296_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads5296_pattern_checker
// Brief    : Directed self-checking bench for ads5296_pattern_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ads5296_pattern_checker;

  localparam int NCH = 16;
  localparam int ARM = 8;
`ifdef ADS5296_CHK_PER_CHAN_CNT_EN
  localparam logic [15:0] EXP_CH5 = 16'd1;
`else
  localparam logic [15:0] EXP_CH5 = 16'd0;
`endif

  logic         sclk = 1'b0;
  logic         rst;
  logic [159:0] din;
  logic         din_vld, start, stop;
  logic [1:0]   mode;
  logic [9:0]   pattern;
  logic [31:0]  window_len;
  logic [7:0]   chan_sel;
  logic         busy, done;
  logic [15:0]  err_mask;
  logic [31:0]  total_err_cnt, samples_checked;
  logic [15:0]  chan_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 sclk = ~sclk;

  ads5296_pattern_checker #(.G_NUM_UNITS(4), .G_ARM_SAMPLES(ARM)) dut (
    .sclk(sclk), .rst(rst), .din(din), .din_vld(din_vld), .start(start),
    .stop(stop), .mode(mode), .pattern(pattern), .window_len(window_len),
    .chan_sel(chan_sel), .busy(busy), .done(done), .err_mask(err_mask),
    .total_err_cnt(total_err_cnt), .samples_checked(samples_checked),
    .chan_err_cnt(chan_err_cnt)
  );

  function automatic logic [159:0] all_ch(input logic [9:0] v);
    logic [159:0] r;
    for (int c = 0; c < NCH; c++) r[10*c +: 10] = v;
    return r;
  endfunction

  task automatic cyc(input logic [159:0] d, input logic v);
    din = d; din_vld = v;
    @(negedge sclk);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [9:0] p, input logic [31:0] wl);
    mode = m; pattern = p; window_len = wl; din_vld = 1'b0; start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (err_mask !== 16'h0) begin errors++; $display("FAIL reset_mask got=%0h exp=0", err_mask); end
    checks++; if (total_err_cnt !== 32'h0) begin errors++; $display("FAIL reset_total got=%0h exp=0", total_err_cnt); end
    checks++; if (samples_checked !== 32'h0) begin errors++; $display("FAIL reset_samples got=%0h exp=0", samples_checked); end
    checks++; if (chan_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_chan got=%0h exp=0", chan_err_cnt); end
    rst = 1'b0;
    @(negedge sclk);
  endtask

  task automatic test_fixed();
    do_start(2'd0, 10'h2AA, 32'd100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fixed_busy got=%0h exp=1", busy); end
    repeat (ARM) cyc(all_ch(10'h000), 1'b1);   // arm samples are discarded
    for (int k = 0; k < 100; k++) cyc(all_ch(10'h2AA), 1'b1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fixed_done_early got=%0h exp=0", done); end
    checks++; if (samples_checked !== 32'd100) begin errors++; $display("FAIL fixed_samples got=%0d exp=100", samples_checked); end
    cyc(all_ch(10'h2AA), 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fixed_done got=%0h exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed_busy_end got=%0h exp=0", busy); end
    checks++; if (total_err_cnt !== 32'd0) begin errors++; $display("FAIL fixed_total got=%0h exp=0", total_err_cnt); end
    checks++; if (err_mask !== 16'h0) begin errors++; $display("FAIL fixed_mask got=%0h exp=0", err_mask); end
  endtask

  task automatic test_ramp();
    logic [159:0] v;
    int base, val;
    chan_sel = 8'd5;
    do_start(2'd1, 10'h000, 32'd12);   // restart directly from DONE
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ramp_start_done got=%0h exp=0", done); end
    checks++; if (samples_checked !== 32'd0) begin errors++; $display("FAIL ramp_start_samples got=%0d exp=0", samples_checked); end
    repeat (ARM) cyc(all_ch(10'h000), 1'b1);
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NCH; c++) begin
        base = (c == 3) ? 1020 : c * 37;
        val  = base + k + ((c == 5 && k >= 6) ? 1 : 0);
        v[10*c +: 10] = 10'(val % 1024);
      end
      cyc(v, 1'b1);
      if (k == 6) begin
        checks++; if (err_mask !== 16'h0020) begin errors++; $display("FAIL ramp_mask_lat got=%0h exp=20", err_mask); end
        checks++; if (total_err_cnt !== 32'd0) begin errors++; $display("FAIL ramp_total_lat1 got=%0d exp=0", total_err_cnt); end
      end
      if (k == 7) begin
        checks++; if (total_err_cnt !== 32'd1) begin errors++; $display("FAIL ramp_total_lat2 got=%0d exp=1", total_err_cnt); end
      end
    end
    cyc(all_ch(10'h000), 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ramp_done got=%0h exp=1", done); end
    checks++; if (err_mask !== 16'h0020) begin errors++; $display("FAIL ramp_mask got=%0h exp=20", err_mask); end
    checks++; if (total_err_cnt !== 32'd1) begin errors++; $display("FAIL ramp_total got=%0d exp=1", total_err_cnt); end
    checks++; if (samples_checked !== 32'd12) begin errors++; $display("FAIL ramp_samples got=%0d exp=12", samples_checked); end
    checks++; if (chan_err_cnt !== EXP_CH5) begin errors++; $display("FAIL ramp_chan5 got=%0d exp=%0d", chan_err_cnt, EXP_CH5); end
    chan_sel = 8'd3; #1;
    checks++; if (chan_err_cnt !== 16'd0) begin errors++; $display("FAIL ramp_chan3 got=%0d exp=0", chan_err_cnt); end
    chan_sel = 8'd200; #1;
    checks++; if (chan_err_cnt !== 16'd0) begin errors++; $display("FAIL ramp_chan_oor got=%0d exp=0", chan_err_cnt); end
  endtask

  task automatic test_toggle();
    logic [159:0] v;
    do_start(2'd2, 10'h155, 32'd10);
    repeat (ARM) cyc(all_ch(10'h000), 1'b1);
    for (int k = 0; k < 10; k++) begin
      // channel 0 repeats 0x155 at k=5, then alternates from there
      v[9:0] = (k < 5) ? (((k % 2) == 0) ? 10'h155 : 10'h2AA)
                       : ((((k - 1) % 2) == 0) ? 10'h155 : 10'h2AA);
      for (int c = 1; c < NCH; c++)
        v[10*c +: 10] = (((k + c) % 2) == 0) ? 10'h155 : 10'h2AA;
      cyc(v, 1'b1);
      if (k == 5) begin
        checks++; if (err_mask !== 16'h0001) begin errors++; $display("FAIL toggle_mask_lat got=%0h exp=1", err_mask); end
      end
    end
    cyc(all_ch(10'h000), 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL toggle_done got=%0h exp=1", done); end
    checks++; if (err_mask !== 16'h0001) begin errors++; $display("FAIL toggle_mask got=%0h exp=1", err_mask); end
    checks++; if (total_err_cnt !== 32'd1) begin errors++; $display("FAIL toggle_total got=%0d exp=1", total_err_cnt); end
  endtask

  task automatic test_gapped();
    do_start(2'd0, 10'h000, 32'd10);
    for (int i = 0; i < ARM; i++) begin
      cyc(all_ch(10'h000), 1'b1); cyc(all_ch(10'h3FF), 1'b0); cyc(all_ch(10'h3FF), 1'b0);
    end
    for (int i = 1; i <= 10; i++) begin
      cyc(all_ch(10'h000), 1'b1);
      if (i == 10) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_done_early got=%0h exp=0", done); end
      end else begin
        cyc(all_ch(10'h3FF), 1'b0);
        if (i == 1) begin
          checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_done_mid got=%0h exp=0", done); end
        end
        cyc(all_ch(10'h3FF), 1'b0);
        if (i == 1) begin
          checks++; if (samples_checked !== 32'd1) begin errors++; $display("FAIL gap_hold got=%0d exp=1", samples_checked); end
        end
      end
    end
    cyc(all_ch(10'h3FF), 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got=%0h exp=1", done); end
    checks++; if (samples_checked !== 32'd10) begin errors++; $display("FAIL gap_samples got=%0d exp=10", samples_checked); end
    checks++; if (total_err_cnt !== 32'd0) begin errors++; $display("FAIL gap_total got=%0d exp=0", total_err_cnt); end
  endtask

  task automatic test_start_stop();
    logic [159:0] v;
    v = all_ch(10'h3FF);
    v[9:0] = 10'h000;
    stop = 1'b1; cyc(v, 1'b0); stop = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ss_idle_done got=%0h exp=0", done); end
    checks++; if (samples_checked !== 32'd10) begin errors++; $display("FAIL ss_idle_hold got=%0d exp=10", samples_checked); end
    start = 1'b1; stop = 1'b1; cyc(v, 1'b0); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_both_busy got=%0h exp=0", busy); end
    checks++; if (samples_checked !== 32'd10) begin errors++; $display("FAIL ss_both_hold got=%0d exp=10", samples_checked); end
    // stop during RUN
    do_start(2'd0, 10'h3FF, 32'd0);
    repeat (ARM) cyc(all_ch(10'h3FF), 1'b1);
    repeat (3) cyc(v, 1'b1);
    start = 1'b1; cyc(v, 1'b0); start = 1'b0;
    checks++; if (samples_checked !== 32'd3) begin errors++; $display("FAIL ss_run_start_ign got=%0d exp=3", samples_checked); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_run_busy got=%0h exp=1", busy); end
    repeat (2) cyc(v, 1'b1);
    repeat (2) cyc(v, 1'b0);
    stop = 1'b1; cyc(v, 1'b0); stop = 1'b0;
    repeat (3) cyc(v, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_stop_busy got=%0h exp=0", busy); end
    checks++; if (samples_checked !== 32'd5) begin errors++; $display("FAIL ss_stop_samples got=%0d exp=5", samples_checked); end
    checks++; if (total_err_cnt !== 32'd5) begin errors++; $display("FAIL ss_stop_total got=%0d exp=5", total_err_cnt); end
    checks++; if (err_mask !== 16'h0001) begin errors++; $display("FAIL ss_stop_mask got=%0h exp=1", err_mask); end
    // rst during RUN
    do_start(2'd0, 10'h3FF, 32'd0);
    checks++; if (samples_checked !== 32'd0) begin errors++; $display("FAIL rr_start_clear got=%0d exp=0", samples_checked); end
    repeat (ARM) cyc(all_ch(10'h3FF), 1'b1);
    repeat (4) cyc(v, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, err_mask, total_err_cnt, samples_checked, chan_err_cnt} !== 98'd0) begin
      errors++; $display("FAIL rr_async busy=%0h done=%0h mask=%0h total=%0d samples=%0d chan=%0d exp all 0",
                         busy, done, err_mask, total_err_cnt, samples_checked, chan_err_cnt); end
    @(negedge sclk); rst = 1'b0;
    repeat (3) cyc(v, 1'b1);
    checks++; if ({busy, done, err_mask, total_err_cnt, samples_checked} !== 82'd0) begin
      errors++; $display("FAIL rr_after busy=%0h done=%0h mask=%0h total=%0d samples=%0d exp all 0",
                         busy, done, err_mask, total_err_cnt, samples_checked); end
  endtask

  task automatic test_saturation();
    do_start(2'd0, 10'h000, 32'd0);
    repeat (ARM) cyc(all_ch(10'h3FF), 1'b1);
    repeat (2) cyc(all_ch(10'h3FF), 1'b1);
    force dut.total_err_cnt_q = 32'hFFFF_FFF0;
    cyc(all_ch(10'h3FF), 1'b1);
    release dut.total_err_cnt_q;
    cyc(all_ch(10'h3FF), 1'b1);
    checks++; if (total_err_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_total got=%0h exp=ffffffff", total_err_cnt); end
    checks++; if (err_mask !== 16'hFFFF) begin errors++; $display("FAIL sat_mask got=%0h exp=ffff", err_mask); end
    cyc(all_ch(10'h3FF), 1'b1);
    checks++; if (total_err_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ffffffff", total_err_cnt); end
    checks++; if (samples_checked !== 32'd5) begin errors++; $display("FAIL sat_samples got=%0d exp=5", samples_checked); end
    stop = 1'b1; cyc(all_ch(10'h000), 1'b0); stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vld = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 2'd0; pattern = '0; window_len = '0; chan_sel = '0;
    test_reset();
    test_fixed();
    test_ramp();
    test_toggle();
    test_gapped();
    test_start_stop();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
